// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the register file write port
// and the hazard lookup.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
);
  logic          s0_valid;
  logic [AW-1:0] s0_rd;
  logic [DW-1:0] s0_data;
  logic          s0_ready;
  logic          s1_valid;
  logic [AW-1:0] s1_rd;
  logic [DW-1:0] s1_data;
  logic          s1_ready;
  logic          wb_wrt;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] chk_rd;
  logic          chk_hit;

  modport slave (
    input  s0_valid, s0_rd, s0_data, s1_valid, s1_rd, s1_data, chk_rd,
    output s0_ready, s1_ready, wb_wrt, wb_rd, wb_data, chk_hit
  );

  modport master (
    output s0_valid, s0_rd, s0_data, s1_valid, s1_rd, s1_data, chk_rd,
    input  s0_ready, s1_ready, wb_wrt, wb_rd, wb_data, chk_hit
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the single register file write port.
// WB_RR_ARB_EN selects round-robin; otherwise fixed load priority with a starvation cap.
module regfile_wb_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  localparam logic [AW-1:0] RD_ZERO = '0;

  logic occ0_q, occ0_d, occ1_q, occ1_d;
  wr_t  slot0_q, slot0_d, slot1_q, slot1_d;
  logic age_q, age_d;            // 1: slot 1 holds the older entry
  logic wb_wrt_q, wb_wrt_d;
  wr_t  wb_q, wb_d;
  logic grant0_c, grant1_c, contend_c, win0_c, fill0_c, fill1_c;

`ifdef WB_RR_ARB_EN
  logic pref0_q, pref0_d;        // 1: slot 0 preferred; reset value prefers slot 1
`else
  logic [1:0] starve_q, starve_d;
`endif

  // Grant from registered slot state only
  always_comb begin
    grant0_c  = 1'b0;
    grant1_c  = 1'b0;
    contend_c = occ0_q && occ1_q && (slot0_q.rd != slot1_q.rd);
`ifdef WB_RR_ARB_EN
    win0_c = pref0_q;
`else
    win0_c = (starve_q == 2'd3);
`endif
    if (occ0_q && occ1_q) begin
      if (contend_c) begin
        grant0_c = win0_c;
        grant1_c = !win0_c;
      end else begin
        grant0_c = !age_q;
        grant1_c = age_q;
      end
    end else begin
      grant0_c = occ0_q;
      grant1_c = occ1_q;
    end
  end

  assign bus.s0_ready = !occ0_q || grant0_c;
  assign bus.s1_ready = !occ1_q || grant1_c;

  // Next state: accept, issue, age and policy update
  always_comb begin
    fill0_c  = !rst && bus.s0_valid && bus.s0_ready && (bus.s0_rd != RD_ZERO);
    fill1_c  = !rst && bus.s1_valid && bus.s1_ready && (bus.s1_rd != RD_ZERO);
    occ0_d   = fill0_c || (occ0_q && !grant0_c);
    occ1_d   = fill1_c || (occ1_q && !grant1_c);
    slot0_d  = fill0_c ? '{rd: bus.s0_rd, data: bus.s0_data} : slot0_q;
    slot1_d  = fill1_c ? '{rd: bus.s1_rd, data: bus.s1_data} : slot1_q;
    wb_wrt_d = grant0_c || grant1_c;
    wb_d     = wb_q;
    if (grant1_c) wb_d = slot1_q;
    else if (grant0_c) wb_d = slot0_q;

    age_d = age_q;
    if (fill0_c && fill1_c) age_d = 1'b1;
    else if (fill0_c && occ1_q && !grant1_c) age_d = 1'b1;
    else if (fill1_c && occ0_q && !grant0_c) age_d = 1'b0;

`ifdef WB_RR_ARB_EN
    pref0_d = pref0_q;
    if (contend_c) pref0_d = !pref0_q;
`else
    starve_d = starve_q;
    if (grant0_c) starve_d = 2'd0;
    else if (contend_c) starve_d = starve_q + 2'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ0_q   <= 1'b0;
      occ1_q   <= 1'b0;
      slot0_q  <= '0;
      slot1_q  <= '0;
      age_q    <= 1'b0;
      wb_wrt_q <= 1'b0;
      wb_q     <= '0;
`ifdef WB_RR_ARB_EN
      pref0_q  <= 1'b0;
`else
      starve_q <= 2'd0;
`endif
    end else begin
      occ0_q   <= occ0_d;
      occ1_q   <= occ1_d;
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      age_q    <= age_d;
      wb_wrt_q <= wb_wrt_d;
      wb_q     <= wb_d;
`ifdef WB_RR_ARB_EN
      pref0_q  <= pref0_d;
`else
      starve_q <= starve_d;
`endif
    end
  end

  assign bus.wb_wrt  = wb_wrt_q;
  assign bus.wb_rd   = wb_q.rd;
  assign bus.wb_data = wb_q.data;

  // Pending-write lookup for read hazard stalls
  assign bus.chk_hit = (bus.chk_rd != RD_ZERO) &&
                       ((occ0_q && (slot0_q.rd == bus.chk_rd)) ||
                        (occ1_q && (slot1_q.rd == bus.chk_rd)) ||
                        (wb_wrt_q && (wb_q.rd == bus.chk_rd)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized
// traffic compared against a timestamp-based reference model.
module tb_regfile_wb_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();
  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Register file fed by the arbiter's write port
  logic [31:0] rf [64];
  always @(posedge clk) if (bus.wb_wrt === 1'b1) rf[bus.wb_rd] <= bus.wb_data;

  // Reference model: pending entries stamped with their arrival edge
  bit        m_v [2];
  bit [5:0]  m_rd [2];
  bit [31:0] m_data [2];
  int        m_t [2];
  bit        m_wrt;
  bit [5:0]  m_wrd;
  bit [31:0] m_wdata;
  int        m_pref;
  int        m_lost;
  int        m_now = 0;

  function automatic void m_clear();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_rd[k] = 0; m_data[k] = 0; m_t[k] = 0;
    end
    m_wrt = 0; m_wrd = 0; m_wdata = 0; m_pref = 1; m_lost = 0;
  endfunction

  function automatic int m_grant();
    if (m_v[0] && m_v[1]) begin
      if (m_rd[0] == m_rd[1]) return (m_t[1] <= m_t[0]) ? 1 : 0;
`ifdef WB_RR_ARB_EN
      return m_pref;
`else
      return (m_lost >= 3) ? 0 : 1;
`endif
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_ready(input int k);
    return !m_v[k] || (m_grant() == k);
  endfunction

  function automatic bit m_hit(input bit [5:0] c);
    if (c == 0) return 0;
    return (m_v[0] && m_rd[0] == c) || (m_v[1] && m_rd[1] == c) || (m_wrt && m_wrd == c);
  endfunction

  function automatic void model_step(input bit r, input bit v0, input bit [5:0] r0,
                                     input bit [31:0] d0, input bit v1,
                                     input bit [5:0] r1, input bit [31:0] d1);
    int g;
    bit a0, a1, contended;
    m_now++;
    if (r) begin
      m_clear();
      return;
    end
    g = m_grant();
    contended = m_v[0] && m_v[1] && (m_rd[0] != m_rd[1]);
    a0 = v0 && m_ready(0) && (r0 != 0);
    a1 = v1 && m_ready(1) && (r1 != 0);
    m_wrt = (g >= 0);
    if (g >= 0) begin
      m_wrd = m_rd[g]; m_wdata = m_data[g]; m_v[g] = 0;
    end
`ifdef WB_RR_ARB_EN
    if (contended) m_pref = 1 - g;
`else
    if (g == 0) m_lost = 0;
    else if (contended) m_lost++;
`endif
    if (a0) begin m_v[0] = 1; m_rd[0] = r0; m_data[0] = d0; m_t[0] = m_now; end
    if (a1) begin m_v[1] = 1; m_rd[1] = r1; m_data[1] = d1; m_t[1] = m_now; end
  endfunction

  task automatic drive(input bit v0, input bit [5:0] r0, input bit [31:0] d0,
                       input bit v1, input bit [5:0] r1, input bit [31:0] d1,
                       input bit [5:0] c);
    bus.s0_valid = v0; bus.s0_rd = r0; bus.s0_data = d0;
    bus.s1_valid = v1; bus.s1_rd = r1; bus.s1_data = d1;
    bus.chk_rd = c;
    #1;
  endtask

  task automatic step();
    model_step(rst, bus.s0_valid, bus.s0_rd, bus.s0_data, bus.s1_valid, bus.s1_rd, bus.s1_data);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 5, 32'h55, 1, 6, 32'h66, 5);
    step();
    step();
    checks++; if (bus.wb_wrt !== 1'b0) begin errors++; $display("FAIL reset_wrt got %b exp 0", bus.wb_wrt); end
    checks++; if (bus.s0_ready !== 1'b1 || bus.s1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b exp 11", bus.s0_ready, bus.s1_ready); end
    checks++; if (bus.chk_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", bus.chk_hit); end
    rst = 1'b0;
    drive(1, 5, 32'h55, 1, 6, 32'h66, 5);
    step();
    checks++; if (bus.wb_wrt !== 1'b0 || bus.chk_hit !== 1'b1) begin errors++; $display("FAIL first_accept wrt/hit got %b/%b exp 0/1", bus.wb_wrt, bus.chk_hit); end
    checks++; if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b1) begin errors++; $display("FAIL first_accept_ready got %b%b exp 01", bus.s0_ready, bus.s1_ready); end
    step();
    checks++; if (bus.wb_wrt !== 1'b1 || bus.wb_rd !== 6'd6 || bus.wb_data !== 32'h66) begin errors++; $display("FAIL first_write got %b/%0d/%0h exp 1/6/66", bus.wb_wrt, bus.wb_rd, bus.wb_data); end
    idle(4);
  endtask

  task automatic test_single();
    apply_reset();
    drive(1, 7, 2, 0, 0, 0, 7);
    checks++; if (bus.chk_hit !== 1'b0 || bus.s0_ready !== 1'b1) begin errors++; $display("FAIL single_pre hit/ready got %b/%b exp 0/1", bus.chk_hit, bus.s0_ready); end
    step();
    drive(0, 0, 0, 0, 0, 0, 7);
    checks++; if (bus.chk_hit !== 1'b1 || bus.wb_wrt !== 1'b0) begin errors++; $display("FAIL single_e0 hit/wrt got %b/%b exp 1/0", bus.chk_hit, bus.wb_wrt); end
    step();
    checks++; if (bus.wb_wrt !== 1'b1 || bus.wb_rd !== 6'd7 || bus.wb_data !== 32'd2 || bus.chk_hit !== 1'b1) begin errors++; $display("FAIL single_e1 got %b/%0d/%0d/%b exp 1/7/2/1", bus.wb_wrt, bus.wb_rd, bus.wb_data, bus.chk_hit); end
    step();
    checks++; if (bus.wb_wrt !== 1'b0 || bus.chk_hit !== 1'b0 || bus.wb_rd !== 6'd7) begin errors++; $display("FAIL single_e2 wrt/hit/rd got %b/%b/%0d exp 0/0/7", bus.wb_wrt, bus.chk_hit, bus.wb_rd); end
  endtask

  task automatic test_contention();
    int exp_rd;
    apply_reset();
    drive(1, 3, 32'h300, 1, 4, 32'h400, 0);
    step();
    for (int i = 0; i < 12; i++) begin
      drive(1, 3, 32'h300 + 32'(i), 1, 4, 32'h400 + 32'(i), 0);
      step();
`ifdef WB_RR_ARB_EN
      exp_rd = (i % 2 == 0) ? 4 : 3;
`else
      exp_rd = (i % 4 == 3) ? 3 : 4;
`endif
      checks++; if (bus.wb_wrt !== 1'b1 || bus.wb_rd !== 6'(exp_rd)) begin errors++; $display("FAIL contention_%0d wrt/rd got %b/%0d exp 1/%0d", i, bus.wb_wrt, bus.wb_rd, exp_rd); end
      checks++; if (bus.wb_data !== m_wdata) begin errors++; $display("FAIL contention_data_%0d got %0h exp %0h", i, bus.wb_data, m_wdata); end
    end
    idle(4);
  endtask

  task automatic test_same_rd();
    apply_reset();
    drive(0, 0, 0, 1, 11, 5, 11);
    step();
    drive(1, 11, 9, 0, 0, 0, 11);
    checks++; if (bus.s0_ready !== 1'b1) begin errors++; $display("FAIL same_rd_ready got %b exp 1", bus.s0_ready); end
    step();
    drive(0, 0, 0, 0, 0, 0, 11);
    checks++; if (bus.wb_wrt !== 1'b1 || bus.wb_rd !== 6'd11 || bus.wb_data !== 32'd5) begin errors++; $display("FAIL same_rd_first got %b/%0d/%0d exp 1/11/5", bus.wb_wrt, bus.wb_rd, bus.wb_data); end
    step();
    checks++; if (bus.wb_wrt !== 1'b1 || bus.wb_rd !== 6'd11 || bus.wb_data !== 32'd9) begin errors++; $display("FAIL same_rd_second got %b/%0d/%0d exp 1/11/9", bus.wb_wrt, bus.wb_rd, bus.wb_data); end
    step();
    checks++; if (rf[11] !== 32'd9) begin errors++; $display("FAIL same_rd_final got %0d exp 9", rf[11]); end
  endtask

  task automatic test_reg0();
    apply_reset();
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    checks++; if (bus.s0_ready !== 1'b1 || bus.chk_hit !== 1'b0) begin errors++; $display("FAIL reg0_pre ready/hit got %b/%b exp 1/0", bus.s0_ready, bus.chk_hit); end
    step();
    checks++; if (bus.wb_wrt !== 1'b0 || bus.chk_hit !== 1'b0 || bus.s0_ready !== 1'b1) begin errors++; $display("FAIL reg0_e0 wrt/hit/ready got %b/%b/%b exp 0/0/1", bus.wb_wrt, bus.chk_hit, bus.s0_ready); end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if (bus.wb_wrt !== 1'b0) begin errors++; $display("FAIL reg0_e1 wrt got %b exp 0", bus.wb_wrt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1, 3, 32'hA, 1, 4, 32'hB, 3);
    step();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 3);
    step();
    rst = 1'b0;
    checks++; if (bus.wb_wrt !== 1'b0 || bus.s0_ready !== 1'b1 || bus.s1_ready !== 1'b1 || bus.chk_hit !== 1'b0) begin errors++; $display("FAIL reset_mid_1 wrt/rdy/hit got %b/%b%b/%b exp 0/11/0", bus.wb_wrt, bus.s0_ready, bus.s1_ready, bus.chk_hit); end
    step();
    checks++; if (bus.wb_wrt !== 1'b0 || bus.s0_ready !== 1'b1 || bus.s1_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_2 wrt/rdy got %b/%b%b exp 0/11", bus.wb_wrt, bus.s0_ready, bus.s1_ready); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 9) < 7), 6'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 9) < 7), 6'($urandom_range(0, 7)), $urandom(),
            6'($urandom_range(0, 7)));
      checks++; if (bus.s0_ready !== m_ready(0) || bus.s1_ready !== m_ready(1)) begin errors++; $display("FAIL rand_ready_%0d got %b%b exp %b%b", i, bus.s0_ready, bus.s1_ready, m_ready(0), m_ready(1)); end
      checks++; if (bus.wb_wrt !== m_wrt || bus.wb_rd !== m_wrd || bus.wb_data !== m_wdata) begin errors++; $display("FAIL rand_wb_%0d got %b/%0d/%0h exp %b/%0d/%0h", i, bus.wb_wrt, bus.wb_rd, bus.wb_data, m_wrt, m_wrd, m_wdata); end
      checks++; if (bus.chk_hit !== m_hit(bus.chk_rd)) begin errors++; $display("FAIL rand_hit_%0d rd %0d got %b exp %b", i, bus.chk_rd, bus.chk_hit, m_hit(bus.chk_rd)); end
      step();
    end
    rst = 1'b0;
    idle(4);
  endtask

  initial begin
    m_clear();
    for (int i = 0; i < 64; i++) rf[i] = 32'd0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_contention();
    test_same_rd();
    test_reg0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
